counter_seq_ctrl: RTL

Command-driven sequencer sitting directly upstream of the team's 4-bit loadable counter (counter_4bit). It drives the counter's load, load_data and enable inputs, and consumes its counter_is_max flag to count completed count periods. It accepts START/PAUSE/RESUME/LOAD commands over a valid/ready handshake and pulses done after a programmed number of periods.

---
 rtl/counter_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//
// Command-driven sequencer placed directly upstream of the 4-bit loadable
// counter (counter_4bit). It drives the counter's load / load_data / enable
// inputs. It also watches counter_is_max so it can count completed count
// periods. When the programmed number of periods has elapsed it pulses done
// for one cycle.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   cmd_valid      in   command present
//   cmd_ready      out  command can be accepted (low only while loading counter)
//   cmd_op         in   00=START 01=PAUSE 10=RESUME 11=LOAD
//   cmd_data       in   preload value used by LOAD
//   cmd_periods    in   number of periods used by START
//   counter_is_max in   terminal-count flag from the counter
//   load           out  counter load strobe
//   load_data      out  counter load value
//   enable         out  counter count enable
//   busy           out  sequencer not idle
//   done           out  one-cycle pulse when the programmed periods finish
//   periods_left   out  remaining periods
//
// All outputs are registered. Each output is computed from the next state and
// the next values in one combinational block, so that a command's effect is
// visible right after the edge that accepts it.
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int P_DATA_W   = 4,
    parameter int P_PERIOD_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [P_DATA_W-1:0]   cmd_data,
    input  logic [P_PERIOD_W-1:0] cmd_periods,
    input  logic                  counter_is_max,
    output logic                  load,
    output logic [P_DATA_W-1:0]   load_data,
    output logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic [P_PERIOD_W-1:0] periods_left
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOADCTR = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_PAUSED  = 2'd3;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    logic [1:0]            state, state_nxt;
    logic [P_PERIOD_W-1:0] periods_nxt;
    logic                  load_nxt;
    logic [P_DATA_W-1:0]   load_data_nxt;
    logic                  done_nxt;
    logic                  accept;
    logic                  wrap;

    assign accept = cmd_valid && cmd_ready;
    // A wrap is counted only when the counter is actually counting. This uses
    // the registered enable and load values, i.e. what the counter saw on
    // this edge.
    assign wrap = counter_is_max && enable && !load;

    always_comb begin
        state_nxt     = state;
        periods_nxt   = periods_left;
        load_nxt      = 1'b0;
        load_data_nxt = '0;
        done_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_START) begin
                        if (cmd_periods != '0) begin
                            state_nxt   = ST_LOADCTR;
                            periods_nxt = cmd_periods;
                            load_nxt    = 1'b1;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else if (cmd_op == OP_LOAD) begin
                        load_nxt      = 1'b1;
                        load_data_nxt = cmd_data;
                    end
                end
            end

            ST_LOADCTR: begin
                state_nxt = ST_RUN;
            end

            ST_RUN, ST_PAUSED: begin
                // START takes priority over any wrap on the same edge.
                if (accept && cmd_op == OP_START) begin
                    if (cmd_periods != '0) begin
                        state_nxt   = ST_LOADCTR;
                        periods_nxt = cmd_periods;
                        load_nxt    = 1'b1;
                    end else begin
                        state_nxt   = ST_IDLE;
                        periods_nxt = '0;
                        done_nxt    = 1'b1;
                    end
                end else if (state == ST_RUN && wrap && periods_left <= 1) begin
                    // The final wrap swallows any other command on this edge.
                    state_nxt   = ST_IDLE;
                    periods_nxt = '0;
                    done_nxt    = 1'b1;
                end else begin
                    if (state == ST_RUN && wrap) begin
                        periods_nxt = periods_left - 1'b1;
                    end
                    if (accept) begin
                        if (cmd_op == OP_LOAD) begin
                            load_nxt      = 1'b1;
                            load_data_nxt = cmd_data;
                        end else if (cmd_op == OP_PAUSE && state == ST_RUN) begin
                            state_nxt = ST_PAUSED;
                        end else if (cmd_op == OP_RESUME && state == ST_PAUSED) begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            load         <= 1'b0;
            load_data    <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            periods_left <= '0;
            cmd_ready    <= 1'b1;
        end else begin
            state        <= state_nxt;
            load         <= load_nxt;
            load_data    <= load_data_nxt;
            enable       <= (state_nxt == ST_RUN);
            busy         <= (state_nxt != ST_IDLE);
            done         <= done_nxt;
            periods_left <= periods_nxt;
            cmd_ready    <= (state_nxt != ST_LOADCTR);
        end
    end

endmodule
